// File: rtl/pong_pkg.sv
// Shared definitions for the pong game controller.
// Holds the FSM state encoding, the ball direction encoding, the default
// screen/object geometry and the two-digit BCD increment used by both the
// score counters and the win check.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    // POS = right (x) / down (y); NEG = left (x) / up (y).
    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_e;

    localparam int SCREEN_W_DEF     = 640;
    localparam int SCREEN_H_DEF     = 480;
    localparam int BALL_W_DEF       = 8;
    localparam int PADDLE_W_DEF     = 10;
    localparam int PADDLE_LEN_DEF   = 80;
    localparam int PADDLE_L_X_DEF   = 40;
    localparam int PADDLE_R_X_DEF   = 590;
    localparam int BALL_SPEED_DEF   = 2;
    localparam int PADDLE_SPEED_DEF = 4;
    localparam int SERVE_FRAMES_DEF = 60;
    localparam int WIN_SCORE_DEF    = 11;

    // {tens, ones} + 1 in BCD, saturating at 19 (tens is only ever 0 or 1).
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = v[7:4];
        ones = v[3:0];
        if (tens != 4'd0 && ones == 4'd9) begin
            return v;
        end
        if (ones == 4'd9) begin
            return {tens + 4'd1, 4'd0};
        end
        return {tens, ones + 4'd1};
    endfunction

endpackage

// File: rtl/pong_game_controller_bcd2_counter.sv
// Two-digit BCD score counter, saturating at 19.
// Ports:
//   clk_i   - clock
//   rst_i   - asynchronous active-high reset (clears to 00)
//   clr_i   - synchronous clear (new game)
//   inc_i   - synchronous increment by one point
//   tens_o  - tens digit (registered)
//   ones_o  - ones digit (registered)
module bcd2_counter
    import pong_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);

    logic [7:0] val_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            val_q <= '0;
        end else if (clr_i) begin
            val_q <= '0;
        end else if (inc_i) begin
            val_q <= bcd_inc(val_q);
        end
    end

    assign tens_o = val_q[7:4];
    assign ones_o = val_q[3:0];

endmodule

// File: rtl/pong_game_controller.sv
// Per-frame pong game sequencer feeding the VGA renderer.
// On every frame_tick it moves the paddles from the buttons, moves the ball,
// and resolves wall bounces, paddle hits, misses, scoring and game over.
// Ports:
//   clk, reset (async, active-high), frame_tick (1-cycle pulse per frame)
//   start (level; starts a game from IDLE or OVER)
//   btn_l_up/btn_l_down/btn_r_up/btn_r_down - paddle controls
//   ball_x/ball_y          - ball top-left corner (registered)
//   paddle_l_y/paddle_r_y  - paddle top edges (registered)
//   score_*_tens/_ones     - BCD score digits (registered)
//   game_over              - high while in OVER
module pong_game_controller
    import pong_pkg::*;
#(
    parameter int SCREEN_W     = SCREEN_W_DEF,
    parameter int SCREEN_H     = SCREEN_H_DEF,
    parameter int BALL_W       = BALL_W_DEF,
    parameter int PADDLE_W     = PADDLE_W_DEF,
    parameter int PADDLE_LEN   = PADDLE_LEN_DEF,
    parameter int PADDLE_L_X   = PADDLE_L_X_DEF,
    parameter int PADDLE_R_X   = PADDLE_R_X_DEF,
    parameter int BALL_SPEED   = BALL_SPEED_DEF,
    parameter int PADDLE_SPEED = PADDLE_SPEED_DEF,
    parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
    parameter int WIN_SCORE    = WIN_SCORE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       btn_l_up,
    input  logic       btn_l_down,
    input  logic       btn_r_up,
    input  logic       btn_r_down,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic [8:0] paddle_l_y,
    output logic [8:0] paddle_r_y,
    output logic [3:0] score_left_tens,
    output logic [3:0] score_left_ones,
    output logic [3:0] score_right_tens,
    output logic [3:0] score_right_ones,
    output logic       game_over
);

    // All geometry comparisons run on 11-bit values so sums never wrap.
    localparam logic [10:0] C_SW      = 11'(SCREEN_W);
    localparam logic [10:0] C_SH      = 11'(SCREEN_H);
    localparam logic [10:0] C_BW      = 11'(BALL_W);
    localparam logic [10:0] C_PL      = 11'(PADDLE_LEN);
    localparam logic [10:0] C_BS      = 11'(BALL_SPEED);
    localparam logic [10:0] C_PS      = 11'(PADDLE_SPEED);
    localparam logic [10:0] C_PRX     = 11'(PADDLE_R_X);
    localparam logic [10:0] C_L_FACE  = 11'(PADDLE_L_X + PADDLE_W);
    localparam logic [10:0] C_PAD_MAX = 11'(SCREEN_H - PADDLE_LEN);

    localparam logic [9:0] BALL_X0 = 10'((SCREEN_W - BALL_W) / 2);
    localparam logic [8:0] BALL_Y0 = 9'((SCREEN_H - BALL_W) / 2);
    localparam logic [8:0] PAD_Y0  = 9'((SCREEN_H - PADDLE_LEN) / 2);

    localparam int              SC_W       = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [SC_W-1:0] SERVE_LAST = SC_W'(SERVE_FRAMES - 1);
    localparam logic [7:0]      WIN_BCD    = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

    state_e          state_q;
    logic [9:0]      ball_x_q;
    logic [8:0]      ball_y_q;
    logic [8:0]      pad_l_q;
    logic [8:0]      pad_r_q;
    dir_e            dx_q;
    dir_e            dy_q;
    logic [SC_W-1:0] serve_cnt_q;
    logic            right_scored_q;
    logic            game_over_q;

    // One paddle step; both or neither button pressed leaves it in place.
    function automatic logic [8:0] paddle_step(input logic [8:0] y, input logic up,
                                               input logic dn);
        logic [10:0] y11;
        y11 = {2'b00, y};
        if (up && !dn) begin
            if (y11 < C_PS) begin
                return '0;
            end
            return 9'(y11 - C_PS);
        end
        if (dn && !up) begin
            if (y11 + C_PS > C_PAD_MAX) begin
                return 9'(C_PAD_MAX);
            end
            return 9'(y11 + C_PS);
        end
        return y;
    endfunction

    logic [10:0] bx, by, pl, pr;
    logic        hit_l, hit_r, miss_l, miss_r, miss;

    assign bx = {1'b0, ball_x_q};
    assign by = {2'b00, ball_y_q};
    assign pl = {2'b00, pad_l_q};
    assign pr = {2'b00, pad_r_q};

    // Collision checks use the paddle positions from before this frame's move.
    assign hit_l  = (dx_q == DIR_NEG) && (bx >= C_L_FACE) && (bx < C_L_FACE + C_BS) &&
                    (by + C_BW >= pl) && (by <= pl + C_PL);
    assign hit_r  = (dx_q == DIR_POS) && (bx + C_BW <= C_PRX) && (bx + C_BW + C_BS > C_PRX) &&
                    (by + C_BW >= pr) && (by <= pr + C_PL);
    assign miss_l = (dx_q == DIR_NEG) && (bx < C_BS);
    assign miss_r = (dx_q == DIR_POS) && (bx + C_BW + C_BS > C_SW);
    assign miss   = !hit_l && !hit_r && (miss_l || miss_r);

    logic [9:0] ball_x_d;
    logic [8:0] ball_y_d;
    logic [8:0] pad_l_d;
    logic [8:0] pad_r_d;
    dir_e       dx_d;
    dir_e       dy_d;

    always_comb begin
        pad_l_d  = paddle_step(pad_l_q, btn_l_up, btn_l_down);
        pad_r_d  = paddle_step(pad_r_q, btn_r_up, btn_r_down);
        ball_y_d = ball_y_q;
        dy_d     = dy_q;
        ball_x_d = ball_x_q;
        dx_d     = dx_q;

        // Vertical: clamp to the wall and reverse when the next step would leave the screen.
        if (dy_q == DIR_NEG) begin
            if (by < C_BS) begin
                ball_y_d = '0;
                dy_d     = DIR_POS;
            end else begin
                ball_y_d = 9'(by - C_BS);
            end
        end else begin
            if (by + C_BW + C_BS > C_SH) begin
                ball_y_d = 9'(C_SH - C_BW);
                dy_d     = DIR_NEG;
            end else begin
                ball_y_d = 9'(by + C_BS);
            end
        end

        // Horizontal: a paddle hit snaps the ball to the paddle face.
        if (hit_l) begin
            ball_x_d = 10'(C_L_FACE);
            dx_d     = DIR_POS;
        end else if (hit_r) begin
            ball_x_d = 10'(C_PRX - C_BW);
            dx_d     = DIR_NEG;
        end else if (dx_q == DIR_POS) begin
            ball_x_d = 10'(bx + C_BS);
        end else begin
            ball_x_d = 10'(bx - C_BS);
        end
    end

    // Score bookkeeping: POINT lasts one clk and applies the pending increment.
    logic       inc_l, inc_r, clr_scores, win;
    logic [7:0] next_score;

    assign inc_l      = (state_q == ST_POINT) && !right_scored_q;
    assign inc_r      = (state_q == ST_POINT) && right_scored_q;
    assign clr_scores = (state_q == ST_OVER) && start;
    assign next_score = right_scored_q ? bcd_inc({score_right_tens, score_right_ones})
                                       : bcd_inc({score_left_tens, score_left_ones});
    assign win        = (next_score == WIN_BCD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            ball_x_q       <= BALL_X0;
            ball_y_q       <= BALL_Y0;
            pad_l_q        <= PAD_Y0;
            pad_r_q        <= PAD_Y0;
            dx_q           <= DIR_POS;
            dy_q           <= DIR_POS;
            serve_cnt_q    <= '0;
            right_scored_q <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (frame_tick) begin
                        pad_l_q <= pad_l_d;
                        pad_r_q <= pad_r_d;
                        if (serve_cnt_q == SERVE_LAST) begin
                            serve_cnt_q <= '0;
                            state_q     <= ST_PLAY;
                        end else begin
                            serve_cnt_q <= serve_cnt_q + SC_W'(1);
                        end
                    end
                end
                ST_PLAY: begin
                    if (frame_tick) begin
                        pad_l_q <= pad_l_d;
                        pad_r_q <= pad_r_d;
                        if (miss) begin
                            // Ball freezes where it left the field; POINT recentres it.
                            right_scored_q <= miss_l;
                            state_q        <= ST_POINT;
                        end else begin
                            ball_x_q <= ball_x_d;
                            ball_y_q <= ball_y_d;
                            dx_q     <= dx_d;
                            dy_q     <= dy_d;
                        end
                    end
                end
                ST_POINT: begin
                    ball_x_q <= BALL_X0;
                    ball_y_q <= BALL_Y0;
                    // Serve toward the player who just conceded.
                    dx_q     <= right_scored_q ? DIR_NEG : DIR_POS;
                    dy_q     <= (dy_q == DIR_POS) ? DIR_NEG : DIR_POS;
                    if (win) begin
                        game_over_q <= 1'b1;
                        state_q     <= ST_OVER;
                    end else begin
                        state_q <= ST_SERVE;
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        game_over_q <= 1'b0;
                        ball_x_q    <= BALL_X0;
                        ball_y_q    <= BALL_Y0;
                        dx_q        <= DIR_POS;
                        state_q     <= ST_SERVE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    bcd2_counter u_score_l (
        .clk_i  (clk),
        .rst_i  (reset),
        .clr_i  (clr_scores),
        .inc_i  (inc_l),
        .tens_o (score_left_tens),
        .ones_o (score_left_ones)
    );

    bcd2_counter u_score_r (
        .clk_i  (clk),
        .rst_i  (reset),
        .clr_i  (clr_scores),
        .inc_i  (inc_r),
        .tens_o (score_right_tens),
        .ones_o (score_right_ones)
    );

    assign ball_x     = ball_x_q;
    assign ball_y     = ball_y_q;
    assign paddle_l_y = pad_l_q;
    assign paddle_r_y = pad_r_q;
    assign game_over  = game_over_q;

endmodule

// File: tb/tb_pong_game_controller.sv
// Directed bench for pong_game_controller. Plays a full game to 11 through
// the real ports: the ball trajectory with default geometry is fully
// deterministic, so positions and scores below are worked out by hand.
module tb_pong_game_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       start;
    logic       btn_l_up, btn_l_down, btn_r_up, btn_r_down;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic [8:0] paddle_l_y, paddle_r_y;
    logic [3:0] score_left_tens, score_left_ones, score_right_tens, score_right_ones;
    logic       game_over;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    pong_game_controller dut (
        .clk              (clk),
        .reset            (reset),
        .frame_tick       (frame_tick),
        .start            (start),
        .btn_l_up         (btn_l_up),
        .btn_l_down       (btn_l_down),
        .btn_r_up         (btn_r_up),
        .btn_r_down       (btn_r_down),
        .ball_x           (ball_x),
        .ball_y           (ball_y),
        .paddle_l_y       (paddle_l_y),
        .paddle_r_y       (paddle_r_y),
        .score_left_tens  (score_left_tens),
        .score_left_ones  (score_left_ones),
        .score_right_tens (score_right_tens),
        .score_right_ones (score_right_ones),
        .game_over        (game_over)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_ball(input string tag, input int x, input int y);
        chk({tag, "_x"}, 16'(ball_x), 16'(x));
        chk({tag, "_y"}, 16'(ball_y), 16'(y));
    endtask

    task automatic chk_score(input string tag, input int lt, input int lo, input int rt,
                             input int ro);
        chk({tag, "_lt"}, 16'(score_left_tens), 16'(lt));
        chk({tag, "_lo"}, 16'(score_left_ones), 16'(lo));
        chk({tag, "_rt"}, 16'(score_right_tens), 16'(rt));
        chk({tag, "_ro"}, 16'(score_right_ones), 16'(ro));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_ball(tag, 316, 236);
        chk({tag, "_pl"}, 16'(paddle_l_y), 16'd200);
        chk({tag, "_pr"}, 16'(paddle_r_y), 16'd200);
        chk_score(tag, 0, 0, 0, 0);
        chk({tag, "_go"}, 16'(game_over), 16'd0);
    endtask

    // Each frame is a one-cycle pulse followed by one idle cycle; returns on a negedge.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) frame_tick = 1'b1;
            @(negedge clk) frame_tick = 1'b0;
        end
    endtask

    // Safety net: the directed sequence needs well under 100 us.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        start      = 1'b0;
        btn_l_up   = 1'b0;
        btn_l_down = 1'b0;
        btn_r_up   = 1'b0;
        btn_r_down = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;

        // IDLE holds everything, even with a tick and a button.
        btn_l_up = 1'b1;
        ticks(1);
        chk("idle_pl", 16'(paddle_l_y), 16'd200);
        btn_l_up = 1'b0;

        // start together with a frame tick: that tick must not count or move paddles.
        btn_r_down = 1'b1;
        @(negedge clk) begin start = 1'b1; frame_tick = 1'b1; end
        @(negedge clk) begin start = 1'b0; frame_tick = 1'b0; end
        chk("start_pr", 16'(paddle_r_y), 16'd200);

        // Serve: right paddle runs down and clamps at 400; ball held.
        ticks(49);
        chk("srv_pr49", 16'(paddle_r_y), 16'd396);
        ticks(1);
        chk("srv_pr50", 16'(paddle_r_y), 16'd400);
        ticks(9);
        chk("srv_pr59", 16'(paddle_r_y), 16'd400);
        chk_ball("srv59", 316, 236);
        ticks(1);
        chk_ball("srv60", 316, 236);
        btn_r_down = 1'b0;

        // Game 1 point A: dx=+, dy=+.
        ticks(1);
        chk_ball("a_t1", 318, 238);
        btn_l_up = 1'b1;
        ticks(49);
        chk("a_pl_up49", 16'(paddle_l_y), 16'd4);
        ticks(11);
        chk("a_pl_clamp", 16'(paddle_l_y), 16'd0);
        // Both pressed on each side: no movement; start is ignored in PLAY.
        btn_l_down = 1'b1;
        btn_r_up   = 1'b1;
        btn_r_down = 1'b1;
        start      = 1'b1;
        ticks(4);
        chk("a_pl_both", 16'(paddle_l_y), 16'd0);
        chk("a_pr_both", 16'(paddle_r_y), 16'd400);
        start    = 1'b0;
        btn_r_up = 1'b0;
        btn_r_down = 1'b0;
        btn_l_up = 1'b0;
        ticks(50);
        chk("a_pl_down", 16'(paddle_l_y), 16'd200);
        btn_l_down = 1'b0;
        ticks(3);
        chk_ball("a_t118", 552, 472);
        ticks(1);
        chk_ball("a_t119_floor", 554, 472);
        ticks(1);
        chk_ball("a_t120", 556, 470);
        ticks(13);
        chk_ball("a_t133", 582, 444);
        ticks(1);
        chk_ball("a_t134_rhit", 582, 442);
        ticks(1);
        chk_ball("a_t135", 580, 440);
        ticks(220);
        chk_ball("a_t355", 140, 0);
        ticks(1);
        chk_ball("a_t356_ceil", 138, 0);
        ticks(1);
        chk_ball("a_t357", 136, 2);
        ticks(68);
        chk_ball("a_t425", 0, 138);
        ticks(1);
        chk_ball("a_miss_hold", 0, 138);
        chk_score("a_miss", 0, 0, 0, 0);
        @(negedge clk);
        chk_score("a_point", 0, 0, 0, 1);
        chk_ball("a_centre", 316, 236);

        // Point B: serve leftward; left paddle parked at 0 returns the ball.
        btn_l_up = 1'b1;
        ticks(60);
        chk("b_pl_serve", 16'(paddle_l_y), 16'd0);
        chk_ball("b_srv", 316, 236);
        btn_l_up = 1'b0;
        ticks(133);
        chk_ball("b_t133_left", 50, 28);
        ticks(1);
        chk_ball("b_t134_lhit", 50, 30);
        chk_score("b_hit", 0, 0, 0, 1);
        ticks(1);
        chk_ball("b_t135_right", 52, 32);
        btn_l_down = 1'b1;
        ticks(50);
        chk("b_pl_back", 16'(paddle_l_y), 16'd200);
        btn_l_down = 1'b0;
        ticks(240);
        chk_ball("b_t425", 632, 334);
        ticks(1);
        chk_ball("b_miss_hold", 632, 334);
        @(negedge clk);
        chk_score("b_point", 0, 1, 0, 1);

        // Point C repeats point A's trajectory.
        ticks(60 + 426);
        @(negedge clk);
        chk_score("c_point", 0, 1, 0, 2);

        // Points 3..11 for the right player: left paddle misses every serve.
        for (int k = 3; k <= 11; k++) begin
            ticks(60 + 158);
            if (k == 3) begin
                chk_ball("d_t158", 0, 78);
            end
            ticks(1);
            chk({$sformatf("pt%0d_pre", k), "_go"}, 16'(game_over), 16'd0);
            @(negedge clk);
            chk_score($sformatf("pt%0d", k), 0, 1, k / 10, k % 10);
            chk($sformatf("pt%0d_go", k), 16'(game_over), (k == 11) ? 16'd1 : 16'd0);
        end

        // OVER holds positions.
        btn_l_up = 1'b1;
        ticks(1);
        chk("over_pl", 16'(paddle_l_y), 16'd200);
        chk_ball("over_ball", 316, 236);
        chk("over_go", 16'(game_over), 16'd1);
        btn_l_up = 1'b0;

        // Restart from OVER.
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk_score("restart", 0, 0, 0, 0);
        chk("restart_go", 16'(game_over), 16'd0);
        ticks(60);
        chk_ball("g2_srv", 316, 236);
        ticks(1);
        chk_ball("g2_t1", 318, 234);
        ticks(10);
        chk_ball("g2_t11", 338, 214);

        // Reset asserted between clock edges mid-frame: outputs revert at once.
        @(negedge clk) frame_tick = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk) begin frame_tick = 1'b0; reset = 1'b0; end
        ticks(1);
        chk_reset_vals("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
